load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lane_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access opcodes, FSM states and
// request classification helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LB  = 3'b001,
    OP_LBU = 3'b010,
    OP_LH  = 3'b011,
    OP_LHU = 3'b100,
    OP_SW  = 3'b101,
    OP_SB  = 3'b110,
    OP_SH  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_load(op_t op);
    return !(op inside {OP_SW, OP_SB, OP_SH});
  endfunction

  function automatic logic is_misaligned(op_t op, logic [1:0] lo);
    logic mis;
    case (op)
      OP_LH, OP_LHU, OP_SH: mis = lo[0];
      OP_LW, OP_SW:         mis = (lo != 2'b00);
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian lane handling: extracts and extends load data from a word,
// and merges store bytes/halfwords into a word for read-modify-write.
module lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  op_t         op_e;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [3:0]  lane_en;

  assign op_e = op_t'(op);

  always_comb begin
    case (byte_sel)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    half_lane = byte_sel[1] ? word[31:16] : word[15:0];

    case (op_e)
      OP_LW:   load_data = word;
      OP_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  load_data = {24'd0, byte_lane};
      OP_LH:   load_data = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_data = {16'd0, half_lane};
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    lane_en = 4'b0000;
    case (op_e)
      OP_SB:   lane_en[byte_sel] = 1'b1;
      OP_SH:   lane_en = byte_sel[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b0000;
    endcase
  end

  // Odd lanes of a halfword store take the upper byte of the store data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] src;
      if (gi % 2 == 1) begin : g_odd
        assign src = (op_e == OP_SH) ? wdata[15:8] : wdata[7:0];
      end else begin : g_even
        assign src = wdata[7:0];
      end
      assign merged[8*gi +: 8] = lane_en[gi] ? src : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the core and a word-wide data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic [31:0] mem_pc
);

  state_t      state_reg, state_next;
  op_t         op_reg;
  op_t         op_in;
  logic [31:0] addr_reg, wdata_reg, pc_reg, word_reg, rdata_reg;
  logic        misalign_reg;
  logic        req_misaligned;
  logic [31:0] align_word, load_data, merged;

  assign op_in          = op_t'(op);
  assign req_misaligned = is_misaligned(op_in, addr[1:0]);

  // Loads extract straight from memory in READ; stores merge into the captured word.
  assign align_word = (state_reg == ST_READ) ? mem_rd : word_reg;

  lane_align u_lane_align (
    .op        (op_reg),
    .byte_sel  (addr_reg[1:0]),
    .word      (align_word),
    .wdata     (wdata_reg),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (req_misaligned)      state_next = ST_DONE;
          else if (op_in == OP_SW) state_next = ST_WRITE;
          else                     state_next = ST_READ;
        end
      end
      ST_READ:  state_next = is_load(op_reg) ? ST_DONE : ST_WRITE;
      ST_WRITE: state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg       <= OP_LW;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      pc_reg       <= '0;
      word_reg     <= '0;
      rdata_reg    <= '0;
      misalign_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            op_reg    <= op_in;
            addr_reg  <= addr;
            wdata_reg <= wdata;
            pc_reg    <= pc;
            if (req_misaligned) begin
              misalign_reg <= 1'b1;
              rdata_reg    <= '0;
            end
          end
        end
        ST_READ: begin
          word_reg <= mem_rd;
          if (is_load(op_reg)) begin
            rdata_reg    <= load_data;
            misalign_reg <= 1'b0;
          end
        end
        ST_WRITE: begin
          rdata_reg    <= '0;
          misalign_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_reg != ST_IDLE);
  assign done     = (state_reg == ST_DONE);
  assign rdata    = rdata_reg;
  assign misalign = misalign_reg;
  assign mem_addr = {addr_reg[31:2], 2'b00};
  assign mem_we   = (state_reg == ST_WRITE) && !reset;
  assign mem_wd   = (op_reg == OP_SW) ? wdata_reg : merged;
  assign mem_pc   = pc_reg;

endmodule
